// File: rtl/mult_result_buffer.sv
// rtl/mult_result_buffer.sv - captures multiplier products into a FWFT FIFO and acks the multiplier
module mult_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iDone,
    input  logic [2*DATA_WIDTH-1:0] iProduct,
    input  logic                    iReady,
    output logic                    oAck,
    output logic                    oValid,
    output logic [2*DATA_WIDTH-1:0] oProduct,
    output logic [CNT_W-1:0]        oCount,
    output logic                    oFull
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        CAP_WAIT    = 2'd0,
        CAP_ACK     = 2'd1,
        CAP_RELEASE = 2'd2
    } capState_t;

    capState_t state;
    capState_t stateNext;

    logic                    ackNext;
    logic                    push;
    logic                    pop;
    logic [PTR_W-1:0]        wrPtr;
    logic [PTR_W-1:0]        rdPtr;
    logic [CNT_W-1:0]        count;
    logic [2*DATA_WIDTH-1:0] mem [DEPTH];

    // A pop needs a valid head; iReady on an empty FIFO is ignored.
    assign pop      = (count != '0) && iReady;
    assign oValid   = (count != '0);
    assign oFull    = (count == FULL_COUNT);
    assign oCount   = count;
    assign oProduct = oValid ? mem[rdPtr] : '0;

    // Capture FSM next state: one capture per DONE episode, held off while full.
    always_comb begin
        stateNext = CAP_WAIT;
        ackNext   = 1'b0;
        push      = 1'b0;
        case (state)
            CAP_WAIT: begin
                if (iDone && (count < FULL_COUNT)) begin
                    push      = 1'b1;
                    ackNext   = 1'b1;
                    stateNext = CAP_ACK;
                end else begin
                    stateNext = CAP_WAIT;
                end
            end
            CAP_ACK: begin
                stateNext = CAP_RELEASE;
            end
            CAP_RELEASE: begin
                stateNext = iDone ? CAP_RELEASE : CAP_WAIT;
            end
            default: begin
                stateNext = CAP_WAIT;
            end
        endcase
    end

    // State register and the registered acknowledge pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= CAP_WAIT;
            oAck  <= 1'b0;
        end else begin
            state <= stateNext;
            oAck  <= ackNext;
        end
    end

    // FIFO storage is written on capture only and is deliberately never cleared.
    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wrPtr] <= iProduct;
        end
    end

    // Pointers and occupancy; push eligibility uses the pre-edge count.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_result_buffer.sv
// tb/tb_mult_result_buffer.sv - scoreboard bench for mult_result_buffer
module tb_mult_result_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iDone;
    logic [2*DW-1:0] iProduct;
    logic          iReady;
    logic          oAck;
    logic          oValid;
    logic [2*DW-1:0] oProduct;
    logic [CNT_W-1:0] oCount;
    logic          oFull;

    mult_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .iDone(iDone), .iProduct(iProduct),
        .iReady(iReady), .oAck(oAck), .oValid(oValid), .oProduct(oProduct),
        .oCount(oCount), .oFull(oFull)
    );

    always #5 Clock = ~Clock;

    int checkCount = 0;
    int passCount  = 0;
    bit monEn      = 1'b0;
    bit randReady  = 1'b0;

    // Reference model state: occupancy, capture eligibility, expected ack, expected products.
    int  occ       = 0;
    bit  armed     = 1'b1;
    int  sinceCap  = 2;
    bit  mAck      = 1'b0;
    logic [2*DW-1:0] expQ[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: a DONE episode is captured once, at the first edge where it is seen with room
    // in the queue; the next episode is recognised only after iDone has been seen low.
    always @(posedge Clock) begin
        bit doPush;
        bit doPop;
        if (Reset) begin
            occ = 0; armed = 1'b1; sinceCap = 2; mAck = 1'b0;
            expQ.delete();
        end else begin
            doPush = armed && iDone && (occ < DEPTH);
            doPop  = (occ > 0) && iReady;
            mAck   = doPush;
            if (doPush) begin
                armed = 1'b0;
                expQ.push_back(iProduct);
            end else if (!iDone && sinceCap >= 1) begin
                armed = 1'b1;
            end
            sinceCap = doPush ? 0 : ((sinceCap < 10) ? sinceCap + 1 : sinceCap);
            occ = occ + int'(doPush) - int'(doPop);
        end
    end

    // Monitor: compares DUT outputs to the model away from the clock edge.
    always @(negedge Clock) begin
        if (monEn) begin
            check("ack", oAck, mAck);
            check("count", oCount, occ);
            check("valid", oValid, occ != 0);
            check("full", oFull, occ == DEPTH);
            if (oValid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_valid", oValid, 0);
                end else begin
                    check("head", oProduct, expQ[0]);
                    if (iReady) void'(expQ.pop_front());
                end
            end else begin
                check("empty_product", oProduct, 0);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        if (randReady) iReady = 1'($urandom_range(0, 1));
    endtask

    task automatic startDone(input logic [2*DW-1:0] p);
        iProduct = p;
        iDone    = 1'b1;
    endtask

    // Behaves like the multiplier: holds DONE until acked, leaves DONE the cycle after.
    task automatic waitAck(input int budget);
        int n;
        n = 0;
        while (!oAck && n < budget) begin
            tick();
            n++;
        end
        if (!oAck) check("ack_timeout", oAck, 1);
        tick();
        iDone = 1'b0;
        tick();
    endtask

    task automatic episode(input logic [2*DW-1:0] p);
        startDone(p);
        waitAck(200);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        Reset = 1'b1; iDone = 1'b0; iReady = 1'b0; iProduct = '0;
        tick();
        tick();
        check("rst_ack", oAck, 0);
        check("rst_valid", oValid, 0);
        check("rst_count", oCount, 0);
        check("rst_full", oFull, 0);
        check("rst_product", oProduct, 0);
        Reset = 1'b0;
        monEn = 1'b1;

        // Single capture while DONE lingers for three cycles.
        startDone(64'h0000_0003_0000_0005);
        tick();
        check("t1_ack", oAck, 1);
        check("t1_valid", oValid, 1);
        check("t1_product", oProduct, 64'h0000_0003_0000_0005);
        check("t1_count", oCount, 1);
        tick();
        check("t1_ack_once_a", oAck, 0);
        tick();
        check("t1_ack_once_b", oAck, 0);
        iDone = 1'b0;
        tick();
        tick();
        check("t1_no_second", oCount, 1);
        iReady = 1'b1; tick(); iReady = 1'b0; tick();

        // Backpressure: third episode stalls until a slot frees.
        episode(64'd1);
        episode(64'd2);
        check("t2_full", oFull, 1);
        startDone(64'd3);
        repeat (3) begin
            tick();
            check("t2_stall_ack", oAck, 0);
        end
        iReady = 1'b1; tick(); iReady = 1'b0;
        check("t2_pop_no_push", oAck, 0);
        check("t2_pop_count", oCount, 1);
        waitAck(10);
        check("t2_count", oCount, 2);
        check("t2_head", oProduct, 64'd2);
        iReady = 1'b1; repeat (3) tick(); iReady = 1'b0;

        // Streaming with consumer always ready; pointers wrap repeatedly.
        iReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            episode(64'h100 + 64'(i));
            check("t3_count_le1", oCount <= 1, 1);
        end
        tick();
        iReady = 1'b0;

        // Simultaneous push and pop at occupancy 1.
        episode(64'd7);
        iReady = 1'b1;
        startDone(64'd9);
        tick();
        iReady = 1'b0;
        check("t4_count", oCount, 1);
        check("t4_head", oProduct, 64'd9);
        waitAck(10);
        iReady = 1'b1; tick(); iReady = 1'b0; tick();

        // Reset while full and acknowledging.
        episode(64'hA);
        startDone(64'hB);
        n = 0;
        while (!oAck && n < 20) begin tick(); n++; end
        check("t5_pre_count", oCount, 2);
        Reset = 1'b1; iDone = 1'b0;
        tick();
        Reset = 1'b0;
        check("t5_ack", oAck, 0);
        check("t5_valid", oValid, 0);
        check("t5_product", oProduct, 0);
        check("t5_count", oCount, 0);
        episode(64'hC);
        check("t5_recapture", oProduct, 64'hC);
        iReady = 1'b1; tick(); iReady = 1'b0; tick();

        // Idle with stray iReady pulses.
        repeat (10) begin
            iReady = 1'($urandom_range(0, 1));
            tick();
        end
        iReady = 1'b0;
        check("t6_count", oCount, 0);

        // Randomised episodes with random consumer readiness.
        randReady = 1'b1;
        repeat (40) begin
            episode({$urandom, $urandom});
            repeat ($urandom_range(0, 3)) tick();
        end
        randReady = 1'b0;
        iReady = 1'b1;
        repeat (4) tick();
        iReady = 1'b0;
        tick();
        check("drain_empty", oValid, 0);

        monEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mult_result_buffer.md
Name: mult_result_buffer

Overview:
Downstream stage of the shift-add multiplier control machine. Captures the finished product while the multiplier sits in its DONE state and returns the one-cycle acknowledge that releases it to IDLE. Captured products are queued in a small first-word-fall-through FIFO and presented to the next consumer with a valid/ready handshake. When the FIFO is full, the acknowledge is withheld, which stalls the multiplier in DONE.

Parameters:
DATA_WIDTH, 32, operand width; product width is 2*DATA_WIDTH.
DEPTH, 2, FIFO entries (power of two, >=2).
CNT_W, 2, width of oCount; must hold values 0..DEPTH.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous reset, active-high.
iDone  input  1  multiplier is in DONE; iProduct is stable.
iProduct  input  2*DATA_WIDTH  finished product from the datapath.
iReady  input  1  downstream consumer accepts oProduct this cycle.
oAck  output  1  registered one-cycle pulse to the multiplier's iAck.
oValid  output  1  FIFO non-empty; oProduct is meaningful.
oProduct  output  2*DATA_WIDTH  head-of-FIFO product; 0 when empty.
oCount  output  CNT_W  current FIFO occupancy.
oFull  output  1  oCount == DEPTH.

Behaviour:
- Reset (sampled on a Clock edge while Reset=1):
  - oAck=0, rd/wr pointers=0, count=0, so oValid=0, oFull=0, oCount=0, oProduct=0.
  - Capture FSM goes to CAP_WAIT. FIFO storage is not cleared.
  - Reset mid-transfer discards all queued products and any pending ack.
- Capture FSM states:
  - CAP_WAIT: if iDone=1 and count<DEPTH at the clock edge, write iProduct at wr_ptr, advance wr_ptr (wraps modulo DEPTH), set oAck=1 for the next cycle, go to CAP_ACK. If iDone=1 and full, stay in CAP_WAIT with oAck=0 (backpressure).
  - CAP_ACK: oAck=1 this cycle only; next state CAP_RELEASE; oAck returns to 0.
  - CAP_RELEASE: wait for iDone=0, then go to CAP_WAIT. This guarantees exactly one capture per DONE episode, even if the multiplier lingers in DONE.
  - Any unused state encoding goes to CAP_WAIT with oAck=0.
- Latency:
  - iDone rising (FIFO not full) -> product written and oAck high 1 cycle later.
  - oValid rises in the same cycle oAck is high.
  - Multiplier reaches IDLE the cycle after oAck.
- Read side (first-word fall-through):
  - oValid = (count != 0).
  - oProduct = mem[rd_ptr] when oValid, else 0.
  - Pop occurs when oValid && iReady at the edge; rd_ptr advances and wraps.
  - iReady while empty has no effect.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push eligibility uses the count before the edge. When full, a pop in the same cycle does not enable a push; the capture happens one cycle later.
- Count arithmetic: +1 on push only, -1 on pop only. It never exceeds DEPTH and never goes below 0.

Test Plan:
1. Reset, then iProduct=64'h0000_0003_0000_0005 with iDone=1 for 3 cycles -> oAck high exactly 1 cycle, 1 cycle after iDone; oValid=1; oProduct=64'h0000_0003_0000_0005; oCount=1; no second capture while iDone is held.
2. With iReady=0, perform three DONE episodes with products 1, 2, 3 -> first two each acked; oFull=1 after second; third stalls with oAck=0. Raise iReady for 1 cycle -> pops 1; 1 cycle later the third is acked and captured; FIFO holds 2, 3.
3. Keep iReady=1 and repeatedly run DONE episodes -> each product appears at oProduct in order; pointers wrap past DEPTH; oCount stays at most 1.
4. Push and pop in the same cycle with oCount=1 (head=7, incoming=9) -> oCount stays 1; oProduct becomes 9 next cycle.
5. Assert Reset while oCount=2 and in CAP_ACK -> next cycle oAck=0, oValid=0, oProduct=0, oCount=0; a new DONE episode is captured normally afterwards.
6. Pulse iReady while empty, and hold iDone=0 for 10 cycles -> no state change; oAck stays 0; oCount stays 0.
